// File: rtl/counter_sequencer.sv
`timescale 1ns/1ps
// Run-control FSM and count register stepped by an internal prescaler tick.
// Optional auto-reload at terminal count when CNT_SEQ_AUTORELOAD_EN is defined.
module counter_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 50000000,
    parameter int PS_W     = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
`ifdef CNT_SEQ_AUTORELOAD_EN
    input  logic             auto_reload,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_t           state_q;
    logic [PS_W-1:0]  ps_q;
    logic [WIDTH-1:0] count_q;
    logic             tick_q;
    logic [WIDTH-1:0] next_count;
    logic             reload;

    // NOTE: always_comb assigns every output on every path, so no latch is inferred.
    always_comb begin
        next_count = dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end

`ifdef CNT_SEQ_AUTORELOAD_EN
    assign reload = auto_reload;
`else
    assign reload = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ps_q    <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // stop and pause outrank start/load even though they do nothing here
                    if (!stop && !pause) begin
                        if (start) begin
                            state_q <= RUN;
                            ps_q    <= '0;
                        end else if (load) begin
                            count_q <= load_val;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (pause) begin
                        state_q <= PAUSE;
                    end else if (ps_q == PS_LAST) begin
                        ps_q   <= '0;
                        tick_q <= 1'b1;
                        if (next_count == limit && reload) begin
                            count_q <= load_val;
                        end else begin
                            count_q <= next_count;
                            if (next_count == limit) begin
                                state_q <= DONE;
                            end
                        end
                    end else begin
                        ps_q <= ps_q + PS_W'(1);
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (!pause) begin
                        if (start) begin
                            state_q <= RUN;
                        end else if (load) begin
                            count_q <= load_val;
                        end
                    end
                end
                DONE: begin
                    if (stop) begin
                        state_q <= IDLE;
                    end else if (!pause) begin
                        if (start) begin
                            state_q <= RUN;
                            count_q <= load_val;
                            ps_q    <= '0;
                        end else if (load) begin
                            count_q <= load_val;
                        end
                    end
                end
            endcase
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign state = state_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for counter_sequencer with PRESCALE=4, WIDTH=4.
// Stimulus pushes expected tick results; a monitor pops them on each tick.
module tb_counter_sequencer;

    localparam int WIDTH    = 4;
    localparam int PRESCALE = 4;
    localparam int PS_W     = 2;

    localparam logic [1:0] IDLE_S  = 2'b00;
    localparam logic [1:0] RUN_S   = 2'b01;
    localparam logic [1:0] PAUSE_S = 2'b10;
    localparam logic [1:0] DONE_S  = 2'b11;

    typedef struct packed {
        logic [3:0] count;
        logic [1:0] state;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic             stop = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             dir = 1'b1;
    logic [WIDTH-1:0] limit = '0;
`ifdef CNT_SEQ_AUTORELOAD_EN
    logic             auto_reload = 1'b0;
`endif
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [3:0] down_seq [8] = '{4'd0, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9};

    counter_sequencer #(
        .WIDTH   (WIDTH),
        .PRESCALE(PRESCALE),
        .PS_W    (PS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .load       (load),
        .load_val   (load_val),
        .dir        (dir),
        .limit      (limit),
`ifdef CNT_SEQ_AUTORELOAD_EN
        .auto_reload(auto_reload),
`endif
        .count      (count),
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_status(input string tag, input logic [3:0] c, input logic [1:0] s);
        check({tag, ".count"}, count, c);
        check({tag, ".state"}, state, s);
        check({tag, ".busy"}, busy, s == RUN_S);
        check({tag, ".done"}, done, s == DONE_S);
    endtask

    // Drive a one-cycle command pulse; returns at the negedge after it was sampled.
    task automatic cmd(input logic s, input logic p, input logic t, input logic l);
        start = s;
        pause = p;
        stop  = t;
        load  = l;
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [3:0] c, input logic [1:0] s);
        exp_t e;
        e.count = c;
        e.state = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, done, 1);
    endtask

    // Monitor: every tick must match the oldest expected step result.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tick) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_tick", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_count", count, mon_e.count);
                    check("sb_state", state, mon_e.state);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(2);
        check_status("reset", 0, IDLE_S);
        check("reset.tick", tick, 0);
        rst = 1'b0;
        cycles(1);

        // Count up from 3 to limit 7
        dir = 1'b1;
        limit = 4'd7;
        load_val = 4'd3;
        cmd(0, 0, 0, 1);
        check("up.load", count, 3);
        for (int v = 4; v <= 7; v++) push_exp(4'(v), (v == 7) ? DONE_S : RUN_S);
        cmd(1, 0, 0, 0);
        check_status("up.run", 3, RUN_S);
        cycles(3);
        check("up.pre_step", count, 3);
        cycles(1);
        check("up.step1", count, 4);
        check("up.tick1", tick, 1);
        wait_done("up.wait_done", 40);
        cycles(10);
        check_status("up.done", 7, DONE_S);
        check("up.drain", exp_q.size(), 0);

        // Load in DONE, restart from load_val, then async reset mid-run
        load_val = 4'd2;
        cmd(0, 0, 0, 1);
        check_status("done.load", 2, DONE_S);
        load_val = 4'd4;
        push_exp(4'd5, RUN_S);
        cmd(1, 0, 0, 0);
        check_status("restart", 4, RUN_S);
        cycles(4);
        check("restart.count", count, 5);
        check("restart.tick", tick, 1);
        #2 rst = 1'b1;
        #1;
        check_status("async_rst", 0, IDLE_S);
        check("async_rst.tick", tick, 0);
        @(negedge clk);
        rst = 1'b0;
        cycles(1);

        // Count down with wrap from 1 to limit 9
        dir = 1'b0;
        limit = 4'd9;
        load_val = 4'd1;
        cmd(0, 0, 0, 1);
        check("down.load", count, 1);
        for (int i = 0; i < 8; i++) push_exp(down_seq[i], (i == 7) ? DONE_S : RUN_S);
        cmd(1, 0, 0, 0);
        wait_done("down.wait_done", 50);
        cycles(2);
        check_status("down.done", 9, DONE_S);
        check("down.drain", exp_q.size(), 0);

        // Pause mid-prescale, resume, then stop on a step cycle
        cmd(0, 0, 1, 0);
        check_status("done.stop", 9, IDLE_S);
        dir = 1'b1;
        limit = 4'd15;
        load_val = 4'd0;
        cmd(0, 0, 0, 1);
        cmd(1, 0, 0, 0);
        cycles(2);
        cmd(0, 1, 0, 0);
        check_status("pause", 0, PAUSE_S);
        cycles(10);
        check_status("pause.hold", 0, PAUSE_S);
        push_exp(4'd1, RUN_S);
        cmd(1, 0, 0, 0);
        check("resume.c0", count, 0);
        cycles(1);
        check("resume.c1", count, 0);
        cycles(1);
        check("resume.c2", count, 1);
        check("resume.tick", tick, 1);
        cycles(3);
        cmd(0, 0, 1, 0);
        check_status("stop_on_step", 1, IDLE_S);
        check("stop_on_step.tick", tick, 0);
        cycles(6);

        // Coincident commands and load while running
        cmd(1, 0, 1, 0);
        check_status("start_stop", 1, IDLE_S);
        cmd(1, 0, 0, 0);
        check_status("run2", 1, RUN_S);
        cmd(1, 1, 0, 0);
        check_status("pause_start", 1, PAUSE_S);
        cmd(1, 0, 0, 0);
        load_val = 4'd12;
        cmd(0, 0, 0, 1);
        check_status("load_in_run", 1, RUN_S);
        cmd(0, 0, 1, 0);
        check_status("stop2", 1, IDLE_S);
        cycles(6);

`ifdef CNT_SEQ_AUTORELOAD_EN
        // Auto-reload at limit, then drop it to reach DONE
        load_val = 4'd2;
        limit = 4'd4;
        auto_reload = 1'b1;
        cmd(0, 0, 0, 1);
        push_exp(4'd3, RUN_S);
        push_exp(4'd2, RUN_S);
        push_exp(4'd3, RUN_S);
        push_exp(4'd2, RUN_S);
        push_exp(4'd3, RUN_S);
        push_exp(4'd4, DONE_S);
        cmd(1, 0, 0, 0);
        cycles(8);
        check_status("ar.reload1", 2, RUN_S);
        cycles(12);
        check_status("ar.before_drop", 3, RUN_S);
        auto_reload = 1'b0;
        wait_done("ar.wait_done", 10);
        cycles(1);
        check_status("ar.done", 4, DONE_S);
`endif

        cycles(5);
        check("final.drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
